// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit towards a 32-bit word-addressed data memory.
// Define MEM_TIMEOUT_EN to abort an access with err when dm_ack does not arrive in time.
module mem_access_unit #(
  parameter int DataSize      = 32,
  parameter int AddrSize      = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [DataSize-1:0] req_wdata,
  output logic                done,
  output logic                err,
  output logic [DataSize-1:0] mem_read_data,
  output logic                dm_enable,
  output logic                dm_write,
  output logic [AddrSize-1:0] dm_addr,
  output logic [DataSize-1:0] dm_wdata,
  output logic [3:0]          dm_wstrb,
  input  logic [DataSize-1:0] dm_rdata,
  input  logic                dm_ack
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2} state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~off[0];
      2'b10:   is_aligned = (off == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [DataSize-1:0] store_data(input logic [1:0] size, input logic [DataSize-1:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [DataSize-1:0] load_extract(input logic [1:0] size, input logic sgn,
                                                       input logic [1:0] off, input logic [DataSize-1:0] rd);
    logic [DataSize-1:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = {{(DataSize-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extract = {{(DataSize-16){sgn & sh[15]}}, sh[15:0]};
      default: load_extract = rd;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic                  sgn_q, sgn_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic [3:0]            strb_q, strb_d;
  logic [AddrSize-1:0]   addr_q, addr_d;
  logic [DataSize-1:0]   wdata_q, wdata_d;
  logic [DataSize-1:0]   rdata_q, rdata_d;
  logic                  accept_s, req_ok_s, timeout_s;

  assign accept_s = (state_q == ST_IDLE) && req_valid;
  assign req_ok_s = is_aligned(req_size, req_addr[1:0]);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);
  logic [7:0] cnt_q, cnt_d;

  // Wait counter: zero outside ACCESS, counts ACCESS cycles
  always_comb begin
    if (state_q == ST_ACCESS) cnt_d = cnt_q + 8'd1;
    else                      cnt_d = 8'd0;
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign timeout_s = (state_q == ST_ACCESS) && !dm_ack && (cnt_q == CntLast);
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; illegal requests skip ACCESS so the memory never sees them
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = req_ok_s ? ST_ACCESS : ST_DONE;
        else           state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (dm_ack || timeout_s) state_d = ST_DONE;
        else                     state_d = ST_ACCESS;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    dm_enable = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready = 1'b1;
      ST_ACCESS: dm_enable = 1'b1;
      ST_DONE:   done      = 1'b1;
      default:   req_ready = 1'b0;
    endcase
    err = done & err_q;
  end

  // Request capture on a legal accept; fields stay frozen through ACCESS and DONE
  always_comb begin
    if (accept_s && req_ok_s) begin
      addr_d  = {req_addr[AddrSize-1:2], 2'b00};
      write_d = req_write;
      size_d  = req_size;
      sgn_d   = req_signed;
      off_d   = req_addr[1:0];
      wdata_d = req_write ? store_data(req_size, req_wdata) : {DataSize{1'b0}};
      strb_d  = req_write ? store_strb(req_size, req_addr[1:0]) : 4'b0000;
    end else begin
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
    end
  end

  // Completion status and load result; only a completed load touches the result
  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept_s) begin
      err_d = ~req_ok_s;
    end else if ((state_q == ST_ACCESS) && dm_ack) begin
      err_d = 1'b0;
      if (!write_q) rdata_d = load_extract(size_q, sgn_q, off_q, dm_rdata);
      else          rdata_d = rdata_q;
    end else if (timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      strb_q  <= 4'b0000;
      addr_q  <= {AddrSize{1'b0}};
      wdata_q <= {DataSize{1'b0}};
      rdata_q <= {DataSize{1'b0}};
    end else begin
      err_q   <= err_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm_addr       = addr_q;
  assign dm_write      = write_q;
  assign dm_wdata      = wdata_q;
  assign dm_wstrb      = strb_q;
  assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, corner-case sequences and
// randomized transactions checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        done, err, dm_enable, dm_write, dm_ack;
  logic [31:0] mem_read_data, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rd = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(
`ifdef MEM_TIMEOUT_EN
    .TimeoutCycles(4)
`else
    .TimeoutCycles(255)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
    .mem_read_data(mem_read_data), .dm_enable(dm_enable), .dm_write(dm_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waitc;
    logic        e_err;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: derive expected bus values and load result from byte lanes
  function automatic vec_t model(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int waitc, input logic [31:0] prev);
    vec_t v;
    int off, nb;
    logic [31:0] val;
    off = int'(a[1:0]);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.rd = rd; v.waitc = waitc;
    v.e_err  = (sz == 2'd3) || ((off % nb) != 0);
    v.e_addr = a & ~32'd3;
    v.e_wdata = 32'd0;
    v.e_strb  = 4'd0;
    v.e_rd    = prev;
    if (!v.e_err && w) begin
      for (int i = 0; i < 4; i++) begin
        v.e_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        v.e_strb[i] = (i >= off) && (i < off + nb);
      end
    end else if (!v.e_err) begin
      val = 32'd0;
      for (int k = 0; k < nb; k++) val[8*k +: 8] = rd[8*(off+k) +: 8];
      if (sg && nb < 4 && val[8*nb-1])
        for (int k = nb; k < 4; k++) val[8*k +: 8] = 8'hFF;
      v.e_rd = val;
    end
    return v;
  endfunction

  // Drive one request from a negedge and check it through to the return to IDLE
  task automatic run_txn(input vec_t v, input string nm);
    chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.w; req_size = v.sz; req_signed = v.sg;
    req_addr = v.a; req_wdata = v.wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
    if (v.e_err) begin
      chk({nm, ".done"}, 32'(done), 32'd1);
      chk({nm, ".err"}, 32'(err), 32'd1);
      chk({nm, ".en"}, 32'(dm_enable), 32'd0);
    end else begin
      chk({nm, ".en"}, 32'(dm_enable), 32'd1);
      chk({nm, ".busy"}, 32'(req_ready), 32'd0);
      chk({nm, ".write"}, 32'(dm_write), 32'(v.w));
      chk({nm, ".addr"}, dm_addr, v.e_addr);
      chk({nm, ".wdata"}, dm_wdata, v.e_wdata);
      chk({nm, ".strb"}, 32'(dm_wstrb), 32'(v.e_strb));
      for (int k = 0; k < v.waitc; k++) begin
        @(negedge clk);
        chk({nm, ".wait_en"}, 32'(dm_enable), 32'd1);
        chk({nm, ".wait_wdata"}, dm_wdata, v.e_wdata);
      end
      dm_ack = 1'b1; dm_rdata = v.rd;
      @(negedge clk);
      dm_ack = 1'b0; dm_rdata = $urandom();
      chk({nm, ".done"}, 32'(done), 32'd1);
      chk({nm, ".err"}, 32'(err), 32'd0);
      chk({nm, ".en_off"}, 32'(dm_enable), 32'd0);
    end
    chk({nm, ".rdata"}, mem_read_data, v.e_rd);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(done), 32'd0);
    chk({nm, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int   en_cnt, guard;
    logic seen_done;

    //          w     sz     sg    addr          wdata          rdata          wt err   exp_addr      exp_wdata      strb     exp_rd
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 32'h00000103, 32'h000000AB, 32'h00000000, 0, 1'b0, 32'h00000100, 32'hABABABAB, 4'b1000, 32'h00000000};
    tbl[1]  = '{1'b0, 2'b01, 1'b1, 32'h00000202, 32'h00000000, 32'h80011234, 1, 1'b0, 32'h00000200, 32'h00000000, 4'b0000, 32'hFFFF8001};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h00000202, 32'h00000000, 32'h80011234, 0, 1'b0, 32'h00000200, 32'h00000000, 4'b0000, 32'h00008001};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h00000301, 32'h00000000, 32'h123456F0, 2, 1'b0, 32'h00000300, 32'h00000000, 4'b0000, 32'h00000056};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h00000300, 32'h00000000, 32'h123456F0, 0, 1'b0, 32'h00000300, 32'h00000000, 4'b0000, 32'hFFFFFFF0};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h00000402, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 4'b0000, 32'hFFFFFFF0};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 32'h00000404, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 4'b0000, 32'hFFFFFFF0};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h00000408, 32'hDEADBEEF, 32'h00000000, 1, 1'b0, 32'h00000408, 32'hDEADBEEF, 4'b1111, 32'hFFFFFFF0};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000040A, 32'h1234CAFE, 32'h00000000, 0, 1'b0, 32'h00000408, 32'hCAFECAFE, 4'b1100, 32'hFFFFFFF0};
    tbl[9]  = '{1'b0, 2'b10, 1'b1, 32'h0000040C, 32'h00000000, 32'h87654321, 0, 1'b0, 32'h0000040C, 32'h00000000, 4'b0000, 32'h87654321};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h00000411, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 4'b0000, 32'h87654321};

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.en", 32'(dm_enable), 32'd0);
    chk("rst.write", 32'(dm_write), 32'd0);
    chk("rst.addr", dm_addr, 32'd0);
    chk("rst.wdata", dm_wdata, 32'd0);
    chk("rst.strb", 32'(dm_wstrb), 32'd0);
    chk("rst.rdata", mem_read_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      model_rd = tbl[i].e_rd;
    end

    // A request held through DONE must not be taken until IDLE
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_addr = 32'h600;
    @(posedge clk); @(negedge clk);
    chk("indone.done", 32'(done), 32'd1);
    chk("indone.err", 32'(err), 32'd1);
    req_size = 2'b10; req_addr = 32'h604;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("indone.not_taken", 32'(dm_enable), 32'd0);
    chk("indone.ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Reset in the middle of a pending access, then a stray ack in IDLE
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h500;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rstmid.en_before", 32'(dm_enable), 32'd1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    model_rd = 32'd0;
    chk("rstmid.en", 32'(dm_enable), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("stray_ack.done", 32'(done), 32'd0);
    chk("stray_ack.en", 32'(dm_enable), 32'd0);
    chk("stray_ack.rdata", mem_read_data, 32'd0);
    v = model(1'b0, 2'b00, 1'b0, 32'h503, 32'd0, 32'hAB000000, 1, model_rd);
    run_txn(v, "after_rst");
    model_rd = v.e_rd;

`ifdef MEM_TIMEOUT_EN
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h700;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    en_cnt = 0; guard = 0;
    while (!done && guard < 20) begin
      if (dm_enable) en_cnt++;
      @(negedge clk);
      guard++;
    end
    chk("timeout.done", 32'(done), 32'd1);
    chk("timeout.en_cycles", 32'(en_cnt), 32'd4);
    chk("timeout.err", 32'(err), 32'd1);
    chk("timeout.rdata", mem_read_data, model_rd);
    @(negedge clk);
`else
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h700;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    seen_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("notimeout.en", 32'(dm_enable), 32'd1);
    chk("notimeout.no_done", 32'(seen_done), 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h11223344;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("notimeout.done", 32'(done), 32'd1);
    chk("notimeout.rdata", mem_read_data, 32'h11223344);
    model_rd = 32'h11223344;
    @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef MEM_TIMEOUT_EN
      v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom(), $urandom(), $urandom(), int'($urandom_range(0, 3)), model_rd);
`else
      v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom(), $urandom(), $urandom(), int'($urandom_range(0, 6)), model_rd);
`endif
      run_txn(v, $sformatf("rnd%0d", i));
      model_rd = v.e_rd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory side of the CPU datapath; generates the `mem_read_data` word consumed by the write-back select mux.
- Accepts one load/store request from the execute stage and performs byte/half/word access to a 32-bit word-addressed data memory with a valid/ack handshake.
- Stores: aligns store data and generates byte strobes.
- Loads: extracts, then sign- or zero-extends, the addressed lanes.
- Byte order is little-endian.

Parameters:
- DataSize, 32, data path width; only 32 is supported.
- AddrSize, 32, byte address width.
- TimeoutCycles, 255, maximum cycles waiting for `dm_ack`; used only with `MEM_TIMEOUT_EN`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  AddrSize  byte address.
- req_wdata  in  DataSize  store data, right-justified.
- done  out  1  one-cycle pulse when the request completes.
- err  out  1  valid with `done`: misaligned, illegal size, or timeout.
- mem_read_data  out  DataSize  extended load result; held until the next successful load.
- dm_enable  out  1  memory access valid.
- dm_write  out  1  memory write.
- dm_addr  out  AddrSize  word address, `{req_addr[AddrSize-1:2], 2'b00}`.
- dm_wdata  out  DataSize  replicated store data.
- dm_wstrb  out  4  byte enables; bit i = byte lane i.
- dm_rdata  in  DataSize  memory read word; valid when `dm_ack` = 1.
- dm_ack  in  1  access complete.

Behaviour:
- Reset (rst = 0 at an edge):
  - State goes to IDLE.
  - `req_ready` = 1 after reset; `done`, `err`, `dm_enable`, `dm_write` = 0.
  - `dm_addr`, `dm_wdata`, `dm_wstrb`, `mem_read_data` = 0.
  - Reset mid-access abandons the access; `dm_enable` deasserts at that edge.
- State IDLE:
  - `req_ready` = 1.
  - A request is accepted when `req_valid` = 1 at an edge.
  - Accepted request is aligned when: byte always; half requires `addr[0]` = 0; word requires `addr[1:0]` = 0; size 11 is never aligned.
  - Illegal or misaligned request: go to DONE with `err` = 1; no memory access is made.
  - Legal request: register the request fields and go to ACCESS.
- State ACCESS:
  - `dm_enable` = 1; `dm_addr`, `dm_write`, `dm_wdata` and `dm_wstrb` are held stable.
  - `req_ready` = 0.
  - `dm_ack` may arrive in the first ACCESS cycle.
  - On `dm_ack`:
    - Load: latch the extracted result into `mem_read_data`.
    - Go to DONE with `err` = 0, and drop `dm_enable` at the same edge.
- State DONE:
  - `done` = 1 for exactly one cycle, then go to IDLE.
  - `req_ready` = 0; a request presented in DONE is not accepted.
- Latency:
  - Accept edge → ACCESS → DONE pulse: 2 cycles plus memory wait cycles.
  - Error path: `done` is asserted the cycle after accept.
- Store lanes:
  - byte: `dm_wdata` = `{4{wdata[7:0]}}`, strobe = `1 << addr[1:0]`.
  - half: `dm_wdata` = `{2{wdata[15:0]}}`, strobe = `0011` or `1100` selected by `addr[1]`.
  - word: `dm_wdata` = `wdata`, strobe = `1111`.
  - Loads drive strobe `0000` and `dm_wdata` = 0.
- Load extraction:
  - Shift `dm_rdata` right by `addr[1:0]*8`.
  - Take the low 8 or 16 bits and extend per `req_signed`.
  - Word loads ignore `req_signed`.
- `dm_ack` outside ACCESS is ignored.
- `mem_read_data` is unchanged by stores, errors and timeouts.

Optional Feature:
- Macro: `MEM_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TimeoutCycles without ack: drop `dm_enable`, go to DONE with `err` = 1.
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for `dm_ack`.

Test Plan:
- Byte store: addr 0x103, wdata 0x000000AB → `dm_addr` 0x100, `dm_wdata` 0xABABABAB, `dm_wstrb` 1000, `dm_write` 1; `done` 2 cycles after accept with ack on first ACCESS cycle; `err` 0.
- Signed half load: addr 0x202, `dm_rdata` 0x80011234 → `mem_read_data` 0xFFFF8001; unsigned repeat → 0x00008001.
- Unsigned byte load: addr 0x301, `dm_rdata` 0x123456F0 → 0x00000056; signed byte at 0x300 → 0xFFFFFFF0.
- Misaligned word: addr 0x402 → `done` = 1, `err` = 1 the cycle after accept; `dm_enable` never asserted; `mem_read_data` unchanged; same for size 11.
- Reset mid-wait: word load at 0x500, ack withheld 5 cycles, rst = 0 on cycle 3 → IDLE next edge with `dm_enable` 0, no `done`; a later ack is ignored; a new request is accepted afterwards.
- Timeout (`MEM_TIMEOUT_EN` defined, TimeoutCycles = 4): no ack → `dm_enable` high exactly 4 cycles, then `done` = 1, `err` = 1; without the macro, `dm_enable` is still high after 300 cycles.
